// File: rtl/btn_pkg.sv
// Shared encodings and 100 MHz timing defaults for the button press classifier.
package btn_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS1   = 3'd1;
    localparam logic [2:0] ST_WAIT2    = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;

    localparam int unsigned DEF_CNT_W    = 26;
    localparam int unsigned DEF_LONG_CYC = 50_000_000;
    localparam int unsigned DEF_DBL_CYC  = 25_000_000;
    localparam int unsigned DEF_REP_CYC  = 10_000_000;

endpackage

// File: rtl/cycle_timer.sv
// Shared interval counter: clears, increments and flags equality with a terminal.
module cycle_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == terminal);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced presses as short, double or long, with auto-repeat while held.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LONG_CYC = DEF_LONG_CYC,
    parameter int unsigned DBL_CYC  = DEF_DBL_CYC,
    parameter int unsigned REP_CYC  = DEF_REP_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_in,
    input  logic enable,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (LONG_CYC < 2 || longint'(LONG_CYC) > CNT_MAX) begin : g_bad_long
        $error("LONG_CYC out of range");
    end
    if (DBL_CYC < 2 || longint'(DBL_CYC) > CNT_MAX) begin : g_bad_dbl
        $error("DBL_CYC out of range");
    end
    if (REP_CYC < 2 || longint'(REP_CYC) > CNT_MAX) begin : g_bad_rep
        $error("REP_CYC out of range");
    end

    logic [2:0]       state_q, state_d;
    logic             lvl_q;
    logic             rise;
    logic             short_q, short_d;
    logic             dbl_q, dbl_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             tmr_clr, tmr_inc, tmr_hit;
    logic             rep_wrap;
    logic [CNT_W-1:0] tmr_term;

    assign rise = level_in & ~lvl_q;

    always_comb begin
        tmr_term = '0;
        case (state_q)
            ST_PRESS1: tmr_term = CNT_W'(LONG_CYC - 1);
            ST_WAIT2:  tmr_term = CNT_W'(DBL_CYC - 1);
            ST_HOLD:   tmr_term = CNT_W'(REP_CYC - 1);
            default:   tmr_term = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tmr_inc  = 1'b0;
        rep_wrap = 1'b0;
        short_d  = 1'b0;
        dbl_d    = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            // Release beats a simultaneous long expiry.
            ST_PRESS1: begin
                if (!level_in) begin
                    state_d = ST_WAIT2;
                end else if (tmr_hit) begin
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            // A second rise beats a simultaneous double-window timeout.
            ST_WAIT2: begin
                if (rise) begin
                    dbl_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (tmr_hit) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!level_in) begin
                    state_d = ST_IDLE;
                end else if (tmr_hit) begin
                    rep_d    = 1'b1;
                    rep_wrap = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!level_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
            short_d = 1'b0;
            dbl_d   = 1'b0;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            tmr_inc = 1'b0;
        end
        tmr_clr = rep_wrap | (state_d != state_q) | ~enable;
    end

    cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .terminal(tmr_term),
        .hit     (tmr_hit)
    );

    // lvl_q resets high so a button held through reset never looks like a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            lvl_q   <= 1'b1;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= level_in;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = dbl_q;
    assign long_press   = long_q;
    assign repeat_tick  = rep_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed scenario bench for btn_press_classifier (LONG=20, DBL=8, REP=5).
module tb_btn_press_classifier;

    logic clk = 1'b0;
    logic reset_n;
    logic level_in;
    logic enable;
    logic short_press, double_press, long_press, repeat_tick, busy;

    int n_checks = 0;
    int n_fail   = 0;

    int k;
    int c_short, c_dbl, c_long, c_rep, c_busy, c_multi;
    int i_short, i_dbl, i_long, i_rep0, i_rep1;

    always #5 clk = ~clk;

    btn_press_classifier #(
        .CNT_W   (26),
        .LONG_CYC(20),
        .DBL_CYC (8),
        .REP_CYC (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .level_in    (level_in),
        .enable      (enable),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .busy        (busy)
    );

    task automatic clr_obs();
        k = 0;
        c_short = 0; c_dbl = 0; c_long = 0; c_rep = 0;
        c_busy = 0; c_multi = 0;
        i_short = -1; i_dbl = -1; i_long = -1;
        i_rep0 = -1; i_rep1 = -1;
    endtask

    // Drive one level for one edge, then log what the outputs show after it.
    task automatic step(input logic l);
        int np;
        level_in = l;
        @(posedge clk);
        #1;
        np = 0;
        if (short_press)  begin c_short++; np++; if (i_short < 0) i_short = k; end
        if (double_press) begin c_dbl++;   np++; if (i_dbl < 0)   i_dbl = k;   end
        if (long_press)   begin c_long++;  np++; if (i_long < 0)  i_long = k;  end
        if (repeat_tick) begin
            c_rep++; np++;
            if (i_rep0 < 0) i_rep0 = k;
            i_rep1 = k;
        end
        if (busy) c_busy++;
        if (np > 1) c_multi++;
        k++;
    endtask

    task automatic steps(input logic l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        level_in = 1'b0;
        enable   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({short_press, double_press, long_press, repeat_tick, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 00000",
                     {short_press, double_press, long_press, repeat_tick, busy});
        end
        reset_n = 1'b1;
        clr_obs();
        steps(1'b0, 4);
        n_checks++;
        if (c_busy !== 0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %0d want 0", c_busy);
        end
    endtask

    task automatic test_short();
        clr_obs();
        step(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL short_busy: got %b want 1", busy);
        end
        steps(1'b1, 4);
        steps(1'b0, 20);
        n_checks++;
        if (c_short !== 1 || i_short !== 13) begin
            n_fail++;
            $display("FAIL short_pulse: got cnt %0d at %0d want 1 at 13", c_short, i_short);
        end
        n_checks++;
        if (c_dbl + c_long + c_rep !== 0) begin
            n_fail++; $display("FAIL short_other: got %0d want 0", c_dbl + c_long + c_rep);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL short_end_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_double();
        clr_obs();
        steps(1'b1, 4);
        steps(1'b0, 3);
        steps(1'b1, 4);
        steps(1'b0, 20);
        n_checks++;
        if (c_dbl !== 1 || i_dbl !== 7) begin
            n_fail++;
            $display("FAIL double_pulse: got cnt %0d at %0d want 1 at 7", c_dbl, i_dbl);
        end
        n_checks++;
        if (c_short + c_long + c_rep !== 0) begin
            n_fail++; $display("FAIL double_other: got %0d want 0", c_short + c_long + c_rep);
        end
    endtask

    task automatic test_long();
        clr_obs();
        steps(1'b1, 41);
        steps(1'b0, 15);
        n_checks++;
        if (c_long !== 1 || i_long !== 20) begin
            n_fail++;
            $display("FAIL long_pulse: got cnt %0d at %0d want 1 at 20", c_long, i_long);
        end
        n_checks++;
        if (c_rep !== 4 || i_rep0 !== 25 || i_rep1 !== 40) begin
            n_fail++;
            $display("FAIL long_repeat: got cnt %0d first %0d last %0d want 4 25 40",
                     c_rep, i_rep0, i_rep1);
        end
        n_checks++;
        if (c_short + c_dbl !== 0) begin
            n_fail++; $display("FAIL long_other: got %0d want 0", c_short + c_dbl);
        end
        n_checks++;
        if (c_multi !== 0) begin
            n_fail++; $display("FAIL long_onehot: got %0d overlap cycles want 0", c_multi);
        end
    endtask

    task automatic test_held_through_reset();
        reset_n  = 1'b0;
        level_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr_obs();
        steps(1'b1, 10);
        steps(1'b0, 15);
        n_checks++;
        if (c_short + c_dbl + c_long + c_rep + c_busy !== 0) begin
            n_fail++;
            $display("FAIL held_reset: got %0d pulses %0d busy want 0 0",
                     c_short + c_dbl + c_long + c_rep, c_busy);
        end
        clr_obs();
        steps(1'b1, 5);
        steps(1'b0, 20);
        n_checks++;
        if (c_short !== 1 || i_short !== 13) begin
            n_fail++;
            $display("FAIL held_reset_next: got cnt %0d at %0d want 1 at 13", c_short, i_short);
        end
    endtask

    task automatic test_reset_mid_press();
        clr_obs();
        steps(1'b1, 3);
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b want 0", busy);
        end
        reset_n = 1'b1;
        steps(1'b1, 25);
        steps(1'b0, 15);
        n_checks++;
        if (c_short + c_dbl + c_long + c_rep !== 0) begin
            n_fail++;
            $display("FAIL midreset_pulses: got %0d want 0", c_short + c_dbl + c_long + c_rep);
        end
    endtask

    task automatic test_enable();
        clr_obs();
        steps(1'b1, 3);
        enable = 1'b0;
        step(1'b1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL enable_busy: got %b want 0", busy);
        end
        enable = 1'b1;
        steps(1'b1, 30);
        steps(1'b0, 15);
        n_checks++;
        if (c_short + c_dbl + c_long + c_rep !== 0) begin
            n_fail++;
            $display("FAIL enable_pulses: got %0d want 0", c_short + c_dbl + c_long + c_rep);
        end
        n_checks++;
        if (c_busy !== 3) begin
            n_fail++; $display("FAIL enable_idle: got busy cycles %0d want 3", c_busy);
        end
    endtask

    task automatic test_release_at_long();
        clr_obs();
        steps(1'b1, 20);
        steps(1'b0, 20);
        n_checks++;
        if (c_long !== 0) begin
            n_fail++; $display("FAIL corner_rel_long: got %0d want 0", c_long);
        end
        n_checks++;
        if (c_short !== 1 || i_short !== 28) begin
            n_fail++;
            $display("FAIL corner_rel_short: got cnt %0d at %0d want 1 at 28", c_short, i_short);
        end
    endtask

    task automatic test_rise_at_dbl();
        clr_obs();
        steps(1'b1, 5);
        steps(1'b0, 8);
        steps(1'b1, 3);
        steps(1'b0, 15);
        n_checks++;
        if (c_dbl !== 1 || i_dbl !== 13) begin
            n_fail++;
            $display("FAIL corner_rise_dbl: got cnt %0d at %0d want 1 at 13", c_dbl, i_dbl);
        end
        n_checks++;
        if (c_short + c_long + c_rep !== 0) begin
            n_fail++;
            $display("FAIL corner_rise_other: got %0d want 0", c_short + c_long + c_rep);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long();
        test_held_through_reset();
        test_reset_mid_press();
        test_enable();
        test_release_at_long();
        test_rise_at_dbl();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
